regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the fixed 18x64 register file.
- Configurable width and depth, optional hardwired-zero register 0, write-to-read bypass, per-port read enables with valid flags.
- Array is cleared or seeded by a post-reset init sequencer instead of a simulation-only initial block.
- Sits between decode (rs1/rs2/rd) and the ALU/writeback stages of the core datapath.

Parameters:
- XLEN, 64, data width in bits.
- DEPTH, 32, number of registers; must be at least 2; need not be a power of 2.
- AW, $clog2(DEPTH), address width.
- ZERO_REG, 1: register 0 reads as 0 and writes to it are dropped. 0: register 0 is ordinary.
- INIT_MODE, 0: init writes 0 to every entry. 1: init writes the entry index to every entry.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- rd_en1  in  1  read request, port 1.
- rs1  in  AW  read address, port 1.
- rd_en2  in  1  read request, port 2.
- rs2  in  AW  read address, port 2.
- Reg_Write  in  1  write enable.
- rd  in  AW  write address.
- Write_Data  in  XLEN  write data.
- Read_Data1  out  XLEN  registered read data, port 1.
- Read_Data2  out  XLEN  registered read data, port 2.
- rvalid1  out  1  Read_Data1 updated by the previous edge.
- rvalid2  out  1  Read_Data2 updated by the previous edge.
- init_done  out  1  high once the array is initialised.

Behaviour:
- reset low (asynchronous): Read_Data1, Read_Data2 = 0; rvalid1, rvalid2 = 0; init_done = 0; FSM goes to INIT; init counter = 0. Array contents are not reset directly.
- FSM state INIT:
  - Each clk edge writes the init value to entry[cnt], then cnt++.
  - Init value = 0, or cnt when INIT_MODE=1. Entry 0 gets 0 whenever ZERO_REG=1.
  - On the edge writing entry DEPTH-1, go to RUN and set init_done=1.
  - Init therefore takes exactly DEPTH edges after reset rises.
  - Reg_Write, rd_en1 and rd_en2 are ignored; rvalid stays 0.
- FSM state RUN: stays here until reset. Reset mid-INIT or mid-RUN restarts init from cnt=0.
- Write (RUN only): at posedge, entry[rd] <= Write_Data when Reg_Write=1, rd < DEPTH, and not (ZERO_REG and rd=0).
- Read port 1 (RUN only; port 2 is identical):
  - rd_en1=1: at posedge, Read_Data1 <= value and rvalid1 <= 1. Latency is 1 cycle.
  - rd_en1=0: Read_Data1 holds its value and rvalid1 <= 0.
- Read value, in priority order:
  1. rs >= DEPTH -> 0.
  2. ZERO_REG and rs=0 -> 0.
  3. Bypass: Reg_Write=1 and rd=rs, with the write not dropped -> Write_Data (the same-edge write is visible).
  4. Otherwise -> entry[rs].
- Both ports may read the same address in the same cycle; both get identical data.
- Out-of-range write (rd >= DEPTH): dropped silently, no other entry modified.

Decomposition:
- Package regfile_pkg:
  - INIT_ZERO=0 and INIT_INDEX=1 constants.
  - FSM state enum {INIT, RUN}.
  - Default XLEN and DEPTH constants.
- One sub-module, regfile_init_fsm: state register, init counter, init write address/data, init_done.
- Array, bypass and read registers stay in regfile_param.

Test Plan:
- Init timing: DEPTH=32, INIT_MODE=1; release reset -> init_done rises on the 32nd edge. Then read rs1=5, rs2=17 -> next cycle Read_Data1=5, Read_Data2=17, rvalid1=rvalid2=1.
- Write then read: Reg_Write=1, rd=7, Write_Data=64'hDEAD_BEEF_0000_0001; next cycle rd_en1=1, rs1=7 -> Read_Data1 = that value one cycle later.
- Bypass: same cycle Reg_Write=1, rd=9, Write_Data=64'h1234, rd_en2=1, rs2=9 -> Read_Data2=64'h1234 next cycle.
- Zero register: ZERO_REG=1; write rd=0, data 64'hFFFF; read rs1=0 in the same cycle and the next -> Read_Data1=0 both times.
- Reset mid-init: assert reset at init cycle 10 -> outputs 0 immediately. Release -> init_done rises exactly DEPTH edges later. Reg_Write during INIT leaves the entry at its init value.
- Non-power-of-2 and hold: DEPTH=18. Write rd=20 -> no entry changes. Read rs1=20 -> 0. With rd_en1=0, Read_Data1 holds and rvalid1=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
// Contents:
//   INIT_ZERO / INIT_INDEX : selectable init patterns (all zeros / entry index)
//   DEFAULT_XLEN / DEFAULT_DEPTH : default data width and register count
//   state_t                : init sequencer states (INIT, RUN)
package regfile_pkg;

    localparam int INIT_ZERO     = 0;
    localparam int INIT_INDEX    = 1;

    localparam int DEFAULT_XLEN  = 64;
    localparam int DEFAULT_DEPTH = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_init_fsm.sv
// Post-reset init sequencer for the register file.
// After reset is released, it walks every entry once, from 0 up to DEPTH-1,
// and supplies a write address and init value for each one. It then parks in
// RUN until the next reset.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   init_we   out  init write strobe (high for the whole INIT state)
//   init_addr out  entry being initialised this cycle
//   init_data out  value written to init_addr
//   init_done out  high once every entry has been written (state RUN)
module regfile_init_fsm
    import regfile_pkg::*;
#(
    parameter int XLEN      = DEFAULT_XLEN,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AW        = $clog2(DEPTH),
    parameter bit ZERO_REG  = 1'b1,
    parameter int INIT_MODE = INIT_ZERO
) (
    input  logic            clk,
    input  logic            reset,
    output logic            init_we,
    output logic [AW-1:0]   init_addr,
    output logic [XLEN-1:0] init_data,
    output logic            init_done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        init_we    = 1'b0;
        init_addr  = cnt_reg;
        init_data  = '0;
        case (state_reg)
            INIT: begin
                init_we = 1'b1;
                // Entry 0 always initialises to zero when it is the
                // hardwired-zero register, whatever the init pattern.
                if ((INIT_MODE == INIT_INDEX) && !(ZERO_REG && (cnt_reg == '0))) begin
                    init_data = XLEN'(cnt_reg);
                end
                if (cnt_reg == LAST_ADDR) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = INIT;
                cnt_next   = '0;
            end
        endcase
    end

    // state_reg is itself a flop, so this is a registered flag that rises
    // on the same edge that writes the last entry.
    assign init_done = (state_reg == RUN);

endmodule

// File: rtl/regfile_param.sv
// Parametrised two-read / one-write register file.
// Features: configurable width and depth (any DEPTH >= 2), optional hardwired
// zero register 0, write-to-read bypass, registered read ports with per-port
// enables and valid flags, and a post-reset init sequencer that clears or
// seeds the array before normal operation starts.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   rd_en1/2    in   read request, port 1/2
//   rs1/rs2     in   read address, port 1/2
//   Reg_Write   in   write enable
//   rd          in   write address
//   Write_Data  in   write data
//   Read_Data1/2 out registered read data, port 1/2
//   rvalid1/2   out  read data updated by the previous edge
//   init_done   out  high once the array is initialised
module regfile_param
    import regfile_pkg::*;
#(
    parameter int XLEN      = DEFAULT_XLEN,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AW        = $clog2(DEPTH),
    parameter bit ZERO_REG  = 1'b1,
    parameter int INIT_MODE = INIT_ZERO
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rd_en1,
    input  logic [AW-1:0]   rs1,
    input  logic            rd_en2,
    input  logic [AW-1:0]   rs2,
    input  logic            Reg_Write,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] Write_Data,
    output logic [XLEN-1:0] Read_Data1,
    output logic [XLEN-1:0] Read_Data2,
    output logic            rvalid1,
    output logic            rvalid2,
    output logic            init_done
);

    // One extra bit so DEPTH itself is representable and addresses can be
    // range-checked when DEPTH is not a power of two.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];

    logic            init_we;
    logic [AW-1:0]   init_addr;
    logic [XLEN-1:0] init_data;

    regfile_init_fsm #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .ZERO_REG  (ZERO_REG),
        .INIT_MODE (INIT_MODE)
    ) u_init_fsm (
        .clk       (clk),
        .reset     (reset),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .init_done (init_done)
    );

    // A user write takes effect only in RUN, only in range, and never to the
    // hardwired-zero register. The same qualified strobe drives the bypass so
    // a dropped write is never forwarded.
    logic user_we;
    assign user_we = init_done
                   && Reg_Write
                   && ({1'b0, rd} < DEPTH_W)
                   && !(ZERO_REG && (rd == '0));

    // Init and user writes are mutually exclusive (INIT vs RUN).
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_data;

    assign mem_we   = init_we || user_we;
    assign mem_addr = init_we ? init_addr : rd;
    assign mem_data = init_we ? init_data : Write_Data;

    // Array storage is deliberately not reset; the init sequencer owns it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    logic [1:0]      rd_en_vec;
    logic [AW-1:0]   rs_vec     [2];
    logic [XLEN-1:0] rdata_vec  [2];
    logic [1:0]      rvalid_vec;

    assign rd_en_vec = {rd_en2, rd_en1};
    assign rs_vec[0] = rs1;
    assign rs_vec[1] = rs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_read_port
            logic [XLEN-1:0] value_next;
            logic [XLEN-1:0] data_reg;
            logic            valid_reg;

            always_comb begin
                value_next = '0;
                if ({1'b0, rs_vec[gi]} >= DEPTH_W) begin
                    value_next = '0;
                end else if (ZERO_REG && (rs_vec[gi] == '0)) begin
                    value_next = '0;
                end else if (user_we && (rd == rs_vec[gi])) begin
                    value_next = Write_Data;
                end else begin
                    value_next = mem[rs_vec[gi]];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (init_done && rd_en_vec[gi]) begin
                    data_reg  <= value_next;
                    valid_reg <= 1'b1;
                end else begin
                    valid_reg <= 1'b0;
                end
            end

            assign rdata_vec[gi]  = data_reg;
            assign rvalid_vec[gi] = valid_reg;
        end
    endgenerate

    assign Read_Data1 = rdata_vec[0];
    assign Read_Data2 = rdata_vec[1];
    assign rvalid1    = rvalid_vec[0];
    assign rvalid2    = rvalid_vec[1];

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param. Two instances run side by side:
//   A: DEPTH=32, ZERO_REG=1, INIT_MODE=1 (index seed)
//   B: DEPTH=18, ZERO_REG=0, INIT_MODE=0 (zero clear)
// A behavioural model (plain arrays + edge count since reset) predicts every
// output after every clock edge.
module tb_regfile_param;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic            en1 [2];
    logic            en2 [2];
    logic            we  [2];
    logic [AW-1:0]   rs1 [2];
    logic [AW-1:0]   rs2 [2];
    logic [AW-1:0]   rd  [2];
    logic [XLEN-1:0] wd  [2];
    logic [XLEN-1:0] q1  [2];
    logic [XLEN-1:0] q2  [2];
    logic            v1  [2];
    logic            v2  [2];
    logic            done[2];

    regfile_param #(.XLEN(XLEN), .DEPTH(32), .ZERO_REG(1'b1), .INIT_MODE(1)) dut_a (
        .clk(clk), .reset(reset),
        .rd_en1(en1[0]), .rs1(rs1[0]), .rd_en2(en2[0]), .rs2(rs2[0]),
        .Reg_Write(we[0]), .rd(rd[0]), .Write_Data(wd[0]),
        .Read_Data1(q1[0]), .Read_Data2(q2[0]),
        .rvalid1(v1[0]), .rvalid2(v2[0]), .init_done(done[0])
    );

    regfile_param #(.XLEN(XLEN), .DEPTH(18), .ZERO_REG(1'b0), .INIT_MODE(0)) dut_b (
        .clk(clk), .reset(reset),
        .rd_en1(en1[1]), .rs1(rs1[1]), .rd_en2(en2[1]), .rs2(rs2[1]),
        .Reg_Write(we[1]), .rd(rd[1]), .Write_Data(wd[1]),
        .Read_Data1(q1[1]), .Read_Data2(q2[1]),
        .rvalid1(v1[1]), .rvalid2(v2[1]), .init_done(done[1])
    );

    // ---------------- reference model ----------------
    logic [XLEN-1:0] m_mem [2][32];
    int              m_edges [2];
    logic [XLEN-1:0] m_q1 [2];
    logic [XLEN-1:0] m_q2 [2];
    logic            m_v1 [2];
    logic            m_v2 [2];

    int checks   = 0;
    int failures = 0;

    function automatic int dep(int k);
        return (k == 0) ? 32 : 18;
    endfunction

    function automatic bit zr(int k);
        return (k == 0);
    endfunction

    function automatic bit idx_seed(int k);
        return (k == 0);
    endfunction

    function automatic bit write_kept(int k, bit w, int wa);
        return w && (wa < dep(k)) && !(zr(k) && wa == 0);
    endfunction

    function automatic logic [XLEN-1:0] read_val(int k, int a, bit w, int wa,
                                                  logic [XLEN-1:0] wdat);
        if (a >= dep(k))               return '0;
        if (zr(k) && a == 0)           return '0;
        if (write_kept(k, w, wa) && wa == a) return wdat;
        return m_mem[k][a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_q1[k] = '0; m_q2[k] = '0;
            m_v1[k] = 1'b0; m_v2[k] = 1'b0;
            m_edges[k] = 0;
        end
    endtask

    task automatic model_edge();
        logic [XLEN-1:0] n1, n2;
        if (!reset) return;
        for (int k = 0; k < 2; k++) begin
            if (m_edges[k] < dep(k)) begin
                m_mem[k][m_edges[k]] = idx_seed(k) ? XLEN'(m_edges[k]) : '0;
                m_v1[k] = 1'b0;
                m_v2[k] = 1'b0;
                m_edges[k]++;
            end else begin
                n1 = read_val(k, int'(rs1[k]), we[k], int'(rd[k]), wd[k]);
                n2 = read_val(k, int'(rs2[k]), we[k], int'(rd[k]), wd[k]);
                if (en1[k]) begin m_q1[k] = n1; m_v1[k] = 1'b1; end else m_v1[k] = 1'b0;
                if (en2[k]) begin m_q2[k] = n2; m_v2[k] = 1'b1; end else m_v2[k] = 1'b0;
                if (write_kept(k, we[k], int'(rd[k]))) m_mem[k][rd[k]] = wd[k];
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_val(string tag, logic [XLEN-1:0] got, logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(string label);
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("%s q1[%0d]", label, k), q1[k], m_q1[k]);
            check_val($sformatf("%s q2[%0d]", label, k), q2[k], m_q2[k]);
            check_val($sformatf("%s v1[%0d]", label, k), XLEN'(v1[k]), XLEN'(m_v1[k]));
            check_val($sformatf("%s v2[%0d]", label, k), XLEN'(v2[k]), XLEN'(m_v2[k]));
            check_val($sformatf("%s done[%0d]", label, k), XLEN'(done[k]),
                      XLEN'(m_edges[k] >= dep(k)));
        end
    endtask

    task automatic tick(string label);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(label);
        $display("txn %-8s A: we=%b rd=%0d rs=%0d/%0d q=%h/%h v=%b%b d=%b | B: we=%b rd=%0d rs=%0d/%0d q=%h/%h v=%b%b d=%b",
                 label, we[0], rd[0], rs1[0], rs2[0], q1[0], q2[0], v1[0], v2[0], done[0],
                 we[1], rd[1], rs1[1], rs2[1], q1[1], q2[1], v1[1], v2[1], done[1]);
    endtask

    task automatic set_idle();
        for (int k = 0; k < 2; k++) begin
            en1[k] = 1'b0; en2[k] = 1'b0; we[k] = 1'b0;
            rs1[k] = '0; rs2[k] = '0; rd[k] = '0; wd[k] = '0;
        end
    endtask

    task automatic wait_init(string tag);
        int n;
        n = 0;
        while (!done[0] && n < 100) begin
            tick("init");
            n++;
        end
        check_val(tag, XLEN'(n), XLEN'(32));
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        model_reset();
        #1 reset = 1'b0;
        #1;
        check_outputs("reset");
        repeat (2) tick("in_rst");
        reset = 1'b1;

        // Init timing: instance A done on edge 32, B on edge 18 (model).
        wait_init("init_len");

        // Seeded values readable on both ports.
        en1[0] = 1'b1; rs1[0] = 5'd5; en2[0] = 1'b1; rs2[0] = 5'd17;
        tick("rd_seed");
        check_val("seed_rs1", q1[0], 64'd5);
        check_val("seed_rs2", q2[0], 64'd17);
        set_idle();

        // Write then read.
        we[0] = 1'b1; rd[0] = 5'd7; wd[0] = 64'hDEAD_BEEF_0000_0001;
        tick("wr7");
        set_idle();
        en1[0] = 1'b1; rs1[0] = 5'd7;
        tick("rd7");
        check_val("wr_then_rd", q1[0], 64'hDEAD_BEEF_0000_0001);
        set_idle();

        // Same-cycle bypass.
        we[0] = 1'b1; rd[0] = 5'd9; wd[0] = 64'h1234; en2[0] = 1'b1; rs2[0] = 5'd9;
        tick("bypass");
        check_val("bypass", q2[0], 64'h1234);
        set_idle();

        // Hardwired zero: same cycle and next cycle.
        en1[0] = 1'b1; rs1[0] = 5'd5;
        tick("pre_zero");
        we[0] = 1'b1; rd[0] = 5'd0; wd[0] = 64'hFFFF; rs1[0] = 5'd0;
        tick("zero_wr");
        check_val("zero_same", q1[0], 64'd0);
        we[0] = 1'b0;
        tick("zero_rd");
        check_val("zero_next", q1[0], 64'd0);
        set_idle();

        // Instance B: hold, out-of-range write and read.
        we[1] = 1'b1; rd[1] = 5'd4; wd[1] = 64'hABCD;
        tick("b_wr4");
        set_idle();
        en1[1] = 1'b1; rs1[1] = 5'd4;
        tick("b_rd4");
        en1[1] = 1'b0; rs1[1] = 5'd20;
        tick("b_hold");
        check_val("hold_data", q1[1], 64'hABCD);
        check_val("hold_valid", XLEN'(v1[1]), 64'd0);
        we[1] = 1'b1; rd[1] = 5'd20; wd[1] = 64'h5555_AAAA;
        tick("b_wr20");
        set_idle();
        for (int a = 0; a < 18; a++) begin
            en1[1] = 1'b1; rs1[1] = AW'(a);
            tick("b_scan");
        end
        rs1[1] = 5'd20;
        tick("b_rd20");
        check_val("oor_read", q1[1], 64'd0);
        check_val("oor_valid", XLEN'(v1[1]), 64'd1);
        set_idle();

        // Reset mid-init; writes during init must be ignored.
        en1[0] = 1'b1; rs1[0] = 5'd5;
        tick("pre_rst");
        set_idle();
        reset = 1'b0;
        model_reset();
        #1;
        check_val("async_q1", q1[0], 64'd0);
        check_outputs("async_rst");
        tick("in_rst");
        reset = 1'b1;
        we[0] = 1'b1; rd[0] = 5'd3; wd[0] = 64'h0BAD_0BAD;
        en1[0] = 1'b1; rs1[0] = 5'd3;
        repeat (10) tick("init10");
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs("mid_rst");
        tick("in_rst");
        reset = 1'b1;
        wait_init("reinit_len");
        set_idle();
        en1[0] = 1'b1; rs1[0] = 5'd3;
        tick("rd3");
        check_val("init_wr_ignored", q1[0], 64'd3);
        set_idle();

        // Randomised traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                en1[k] = 1'($urandom_range(0, 1));
                en2[k] = 1'($urandom_range(0, 1));
                we[k]  = 1'($urandom_range(0, 1));
                rd[k]  = AW'($urandom_range(0, 31));
                rs1[k] = ($urandom_range(0, 3) == 0) ? rd[k] : AW'($urandom_range(0, 31));
                rs2[k] = ($urandom_range(0, 3) == 0) ? rd[k] : AW'($urandom_range(0, 31));
                wd[k]  = {$urandom, $urandom};
            end
            tick("rand");
        end
        set_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
